// File: rtl/des_permutation_unit_pkg.sv
// DES IP/FP tables in DES bit numbering (bit 1 = MSB = index 64) and the combinational permute.
// Pure functions and constants: no latency, no flow control.
package des_perm_pkg;

    localparam logic MODE_IP = 1'b0;
    localparam logic MODE_FP = 1'b1;

    localparam int DES_IP [1:64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int DES_FP [1:64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    // Output DES bit i takes input DES bit TABLE[i]; DES bit k sits at vector index 65-k.
    function automatic logic [64:1] des_permute(input logic [64:1] d, input logic mode);
        logic [64:1] r;
        logic [6:0]  dst;
        logic [6:0]  src;
        r = '0;
        for (int i = 1; i <= 64; i++) begin
            dst = 7'(65 - i);
            src = (mode == MODE_IP) ? 7'(65 - DES_IP[i]) : 7'(65 - DES_FP[i]);
            r[dst] = d[src];
        end
        return r;
    endfunction

endpackage

// File: rtl/des_permutation_unit_if.sv
// Block/mode/tag handshake bundle between a source/sink (master) and the permutation unit (slave).
// Valid/ready on both the input and output sides.
interface des_permutation_unit_if #(
    parameter int TAG_WIDTH = 4
);
    logic [64:1]          Input_Text;
    logic                 Input_Mode;
    logic [TAG_WIDTH-1:0] Input_Tag;
    logic                 Input_Valid;
    logic                 Input_Ready;
    logic [64:1]          Permutation_Output;
    logic                 Output_Mode;
    logic [TAG_WIDTH-1:0] Output_Tag;
    logic                 Output_Valid;
    logic                 Output_Ready;
    logic                 Busy;

    modport master (
        output Input_Text, Input_Mode, Input_Tag, Input_Valid, Output_Ready,
        input  Input_Ready, Permutation_Output, Output_Mode, Output_Tag, Output_Valid, Busy
    );

    modport slave (
        input  Input_Text, Input_Mode, Input_Tag, Input_Valid, Output_Ready,
        output Input_Ready, Permutation_Output, Output_Mode, Output_Tag, Output_Valid, Busy
    );
endinterface

// File: rtl/des_permutation_unit_stage.sv
// One valid/ready register slot: 1 cycle latency, in_rdy_o = empty or draining (no skid buffer).
// Data holds when nothing is loaded; only the valid bit moves.
module des_perm_stage #(
    parameter int WIDTH = 69
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld_i,
    input  logic [WIDTH-1:0] in_dat_i,
    output logic             in_rdy_o,
    output logic             out_vld_o,
    output logic [WIDTH-1:0] out_dat_o,
    input  logic             out_rdy_i
);
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    assign in_rdy_o  = !vld_q || out_rdy_i;
    assign out_vld_o = vld_q;
    assign out_dat_o = dat_q;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (in_rdy_o) begin
            vld_d = in_vld_i;
        end
        if (in_rdy_o && in_vld_i) begin
            dat_d = in_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end
endmodule

// File: rtl/des_permutation_unit.sv
// DES IP/FP permutation pipeline: latency PIPE_STAGES cycles, 1 block/cycle.
// Input_Ready follows Output_Ready combinationally through the stage chain; stalls fill upstream.
module des_permutation_unit
    import des_perm_pkg::*;
#(
    parameter int PIPE_STAGES = 1,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    des_permutation_unit_if.slave  bus
);
    localparam int W = 64 + 1 + TAG_WIDTH;

    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_pipe_stages
        $error("des_permutation_unit: PIPE_STAGES must be within 1..4");
    end

    // Index 0 is the input port, index PIPE_STAGES is the last stage feeding the outputs.
    logic [PIPE_STAGES:0] vld;
    logic [PIPE_STAGES:0] rdy;
    logic [W-1:0]         dat [0:PIPE_STAGES];

    assign vld[0] = bus.Input_Valid;
    assign dat[0] = {des_permute(bus.Input_Text, bus.Input_Mode), bus.Input_Mode, bus.Input_Tag};
    assign bus.Input_Ready = rdy[0];
    assign rdy[PIPE_STAGES] = bus.Output_Ready;

    for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
        des_perm_stage #(
            .WIDTH (W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_vld_i  (vld[g]),
            .in_dat_i  (dat[g]),
            .in_rdy_o  (rdy[g]),
            .out_vld_o (vld[g+1]),
            .out_dat_o (dat[g+1]),
            .out_rdy_i (rdy[g+1])
        );
    end

    assign bus.Output_Valid = vld[PIPE_STAGES];
    assign {bus.Permutation_Output, bus.Output_Mode, bus.Output_Tag} = dat[PIPE_STAGES];
    assign bus.Busy = |vld[PIPE_STAGES:1];
endmodule

// File: tb/tb_des_permutation_unit.sv
// Directed bench for des_permutation_unit at PIPE_STAGES 1, 3 and 4 with an independent IP/FP model.
module tb_des_permutation_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    des_permutation_unit_if #(.TAG_WIDTH(4)) u1_if ();
    des_permutation_unit_if #(.TAG_WIDTH(4)) u3_if ();
    des_permutation_unit_if #(.TAG_WIDTH(4)) u4_if ();

    des_permutation_unit #(.PIPE_STAGES(1), .TAG_WIDTH(4)) u1 (.clk(clk), .rst(rst), .bus(u1_if.slave));
    des_permutation_unit #(.PIPE_STAGES(3), .TAG_WIDTH(4)) u3 (.clk(clk), .rst(rst), .bus(u3_if.slave));
    des_permutation_unit #(.PIPE_STAGES(4), .TAG_WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(u4_if.slave));

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // IP source bit for output DES bit i, from the table's row/column structure.
    function automatic int ip_src(input int i);
        int r, c, base;
        r = (i - 1) / 8;
        c = (i - 1) % 8;
        base = (r < 4) ? 2 * (r + 1) : 2 * (r - 4) + 1;
        return base + 8 * (7 - c);
    endfunction

    // DES bit k lives at position 64-k of a [63:0] vector; FP scatters where IP gathers.
    function automatic logic [63:0] m_perm(input logic [63:0] d, input logic mode);
        logic [63:0] r;
        r = '0;
        for (int i = 1; i <= 64; i++) begin
            if (!mode) r[64 - i] = d[64 - ip_src(i)];
            else       r[64 - ip_src(i)] = d[64 - i];
        end
        return r;
    endfunction

    function automatic logic [63:0] blk(input int j);
        return {32'(32'h9E3779B9 * (j + 1)), 32'h7F4A7C15 ^ 32'(j)};
    endfunction

    function automatic logic [68:0] exp_out(input int j);
        return {m_perm(blk(j), j[0]), j[0], 4'(j)};
    endfunction

    task automatic drv1(input logic v, input logic [63:0] t, input logic m, input logic [3:0] g);
        u1_if.Input_Valid = v; u1_if.Input_Text = t; u1_if.Input_Mode = m; u1_if.Input_Tag = g;
    endtask
    task automatic drv3(input logic v, input logic [63:0] t, input logic m, input logic [3:0] g);
        u3_if.Input_Valid = v; u3_if.Input_Text = t; u3_if.Input_Mode = m; u3_if.Input_Tag = g;
    endtask
    task automatic drv4(input logic v, input logic [63:0] t, input logic m, input logic [3:0] g);
        u4_if.Input_Valid = v; u4_if.Input_Text = t; u4_if.Input_Mode = m; u4_if.Input_Tag = g;
    endtask

    initial begin
        logic [63:0] x, y;
        logic        m;
        logic [3:0]  t;
        int          idx, got, seen;

        drv1(1'b0, '0, 1'b0, '0); drv3(1'b0, '0, 1'b0, '0); drv4(1'b0, '0, 1'b0, '0);
        u1_if.Output_Ready = 1'b0; u3_if.Output_Ready = 1'b0; u4_if.Output_Ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_vld1", u1_if.Output_Valid, 0);
        chk("rst_busy1", u1_if.Busy, 0);
        chk("rst_out1", {u1_if.Permutation_Output, u1_if.Output_Mode, u1_if.Output_Tag}, 0);
        chk("rst_vld3", {u3_if.Output_Valid, u3_if.Busy}, 0);
        chk("rst_vld4", {u4_if.Output_Valid, u4_if.Busy}, 0);
        chk("rst_rdy1", u1_if.Input_Ready, 1);
        rst = 1'b0;

        // Known answers through the single-stage unit
        u1_if.Output_Ready = 1'b1;
        drv1(1'b1, 64'h0123456789ABCDEF, 1'b0, 4'h5);
        @(negedge clk);
        chk("kat_ip", {u1_if.Output_Valid, u1_if.Output_Mode, u1_if.Output_Tag, u1_if.Permutation_Output},
            {1'b1, 1'b0, 4'h5, 64'hCC00CCFFF0AAF0AA});
        drv1(1'b1, 64'h0A4CD99543423234, 1'b1, 4'hA);
        @(negedge clk);
        chk("kat_fp", {u1_if.Output_Valid, u1_if.Output_Mode, u1_if.Output_Tag, u1_if.Permutation_Output},
            {1'b1, 1'b1, 4'hA, 64'h85E813540F0AB405});

        // Round trip: forward in a random mode, back in the opposite one
        for (int n = 0; n < 1000; n++) begin
            x = {$urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            t = 4'($urandom_range(0, 15));
            drv1(1'b1, x, m, t);
            @(negedge clk);
            y = u1_if.Permutation_Output;
            chk("rt_fwd", y, m_perm(x, m));
            drv1(1'b1, y, ~m, t);
            @(negedge clk);
            chk("rt_back", {u1_if.Output_Valid, u1_if.Output_Tag, u1_if.Permutation_Output}, {1'b1, t, x});
        end
        drv1(1'b0, '0, 1'b0, '0);

        // Back-to-back through four stages
        u4_if.Output_Ready = 1'b1;
        for (int c = 0; c < 21; c++) begin
            if (c < 16) drv4(1'b1, blk(c), c[0], 4'(c));
            else        drv4(1'b0, '0, 1'b0, '0);
            #1;
            if (c < 16) chk("b2b_rdy", u4_if.Input_Ready, 1);
            if (c >= 4 && c < 20)
                chk("b2b_out", {u4_if.Output_Valid, u4_if.Permutation_Output, u4_if.Output_Mode, u4_if.Output_Tag},
                    {1'b1, exp_out(c - 4)});
            else
                chk("b2b_idle", u4_if.Output_Valid, 0);
            @(negedge clk);
        end

        // Backpressure on three stages, then release
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            if (idx < 5) drv3(1'b1, blk(idx), idx[0], 4'(idx));
            else         drv3(1'b0, '0, 1'b0, '0);
            #1;
            if (u3_if.Input_Valid && u3_if.Input_Ready) idx++;
            if (c >= 3)
                chk("bp_head", {u3_if.Output_Valid, u3_if.Permutation_Output, u3_if.Output_Mode, u3_if.Output_Tag},
                    {1'b1, exp_out(0)});
            @(negedge clk);
        end
        #1;
        chk("bp_accepted", idx, 3);
        chk("bp_rdy_low", u3_if.Input_Ready, 0);
        u3_if.Output_Ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (idx < 5) drv3(1'b1, blk(idx), idx[0], 4'(idx));
            else         drv3(1'b0, '0, 1'b0, '0);
            #1;
            if (u3_if.Output_Valid) begin
                if (got < 5)
                    chk("bp_order", {u3_if.Permutation_Output, u3_if.Output_Mode, u3_if.Output_Tag}, exp_out(got));
                got++;
            end
            if (u3_if.Input_Valid && u3_if.Input_Ready) idx++;
            @(negedge clk);
        end
        chk("bp_count", got, 5);
        chk("bp_busy", u3_if.Busy, 0);

        // Reset with two blocks in flight
        drv4(1'b1, blk(40), 1'b0, 4'h1);
        @(negedge clk);
        drv4(1'b1, blk(41), 1'b1, 4'h2);
        @(negedge clk);
        drv4(1'b0, '0, 1'b0, '0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst", {u4_if.Output_Valid, u4_if.Busy, u4_if.Permutation_Output, u4_if.Output_Mode, u4_if.Output_Tag}, 0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (u4_if.Output_Valid) seen++;
        end
        chk("mid_rst_stale", seen, 0);

        // Alternate IP/FP on the same block
        for (int k = 0; k < 8; k++) begin
            drv1(1'b1, 64'h0123456789ABCDEF, k[0], 4'(k));
            @(negedge clk);
            chk("interleave", {u1_if.Output_Valid, u1_if.Output_Mode, u1_if.Output_Tag, u1_if.Permutation_Output},
                {1'b1, k[0], 4'(k), k[0] ? m_perm(64'h0123456789ABCDEF, 1'b1) : 64'hCC00CCFFF0AAF0AA});
        end
        drv1(1'b0, '0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
